// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM and ALU decoder of a multicycle RV32I subset core.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  state_t r_state, w_next;
  logic w_pc_update, w_branch;
  logic [1:0] w_alu_op;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FETCH;
    else r_state <= w_next;
  assign state = r_state;
  always_comb begin
    w_next = FETCH;
    w_pc_update = 1'b0;
    w_branch = 1'b0;
    w_alu_op = 2'b00;
    AdrSrc = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    case (r_state)
      FETCH: begin
        w_next = DECODE;
        IRWrite = 1'b1;
        w_pc_update = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECUTER;
          OP_I:         w_next = EXECUTEI;
          OP_BEQ:       w_next = BEQ;
          OP_JAL:       w_next = JAL;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR: begin
        w_next = (op == OP_LW) ? MEMREAD : (op == OP_SW) ? MEMWRITE : FETCH;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        w_next = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        w_next = ALUWB;
        ALUSrcA = 2'b10;
        w_alu_op = 2'b10;
      end
      EXECUTEI: begin
        w_next = ALUWB;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_alu_op = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      JAL: begin
        w_next = ALUWB;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pc_update = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end
  assign PCWrite = w_pc_update | (w_branch & zero);
  assign ImmSrc = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
  // sub only for R-type with funct7b5 set; I-type addi ignores bit 30
  logic [2:0] w_alu_dec;
  assign w_alu_dec = (funct3 == 3'b000) ? (({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000) :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;
  assign ALUControl = (w_alu_op == 2'b01) ? 3'b001 : (w_alu_op == 2'b10) ? w_alu_dec : 3'b000;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams against a per-instruction model.
module tb_multicycle_controller;
  logic clk = 1'b0, rst = 1'b1, funct7b5 = 1'b0, zero = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  int tests = 0, fails = 0;
  int exp_state = 0;
  typedef int iq_t[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  // Visited states of a whole instruction, by opcode; its length is the latency.
  function automatic iq_t m_seq(input logic [6:0] o);
    case (o)
      7'b0000011: return '{0, 1, 2, 3, 4};
      7'b0100011: return '{0, 1, 2, 5};
      7'b0110011: return '{0, 1, 6, 8};
      7'b0010011: return '{0, 1, 7, 8};
      7'b1100011: return '{0, 1, 9};
      7'b1101111: return '{0, 1, 10, 8};
      default:    return '{0, 1};
    endcase
  endfunction

  // {AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB} per state
  function automatic logic [9:0] m_moore(input int s);
    case (s)
      0:       return 10'b0010_10_00_10;
      1:       return 10'b0000_00_01_01;
      2:       return 10'b0000_00_10_01;
      3:       return 10'b1000_00_00_00;
      4:       return 10'b0001_01_00_00;
      5:       return 10'b1100_00_00_00;
      6:       return 10'b0000_00_10_00;
      7:       return 10'b0000_00_10_01;
      8:       return 10'b0001_00_00_00;
      9:       return 10'b0000_00_10_00;
      10:      return 10'b0000_00_01_10;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [2:0] m_alu(input int s, input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (s == 9) return 3'd1;
    if (s != 6 && s != 7) return 3'd0;
    case (f3)
      3'd0: return (o[5] && f7) ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] m_imm(input logic [6:0] o);
    return (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 : (o == 7'b1101111) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic m_pcw(input int s, input logic z);
    return (s == 0) || (s == 10) || (s == 9 && z);
  endfunction

  always @(negedge clk) begin
    logic [19:0] act, expv;
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state};
    expv = {m_pcw(exp_state, zero), m_moore(exp_state), m_imm(op),
            m_alu(exp_state, op, funct3, funct7b5), 4'(exp_state)};
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL cycle t=%0t op=%b f3=%0d f7=%b z=%b got=%b want=%b", $time, op, funct3, funct7b5, zero, act, expv);
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, expv);
    end
  endtask

  task automatic step(input int s);
    exp_state = s;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    iq_t q;
    op = o; funct3 = f3; funct7b5 = f7;
    q = m_seq(o);
    foreach (q[i]) begin
      zero = 1'($urandom);
      step(q[i]);
    end
  endtask

  initial begin
    logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
    #1;
    chk("reset_state", state, 0);
    chk("reset_irwrite", IRWrite, 1);
    chk("reset_pcwrite", PCWrite, 1);
    step(0); step(0);
    rst = 1'b0;
    op = 7'b0000011; step(0); step(1); step(2);
    chk("lw_s3", state, 3); chk("lw_adrsrc", AdrSrc, 1);
    step(3);
    chk("lw_s4", state, 4); chk("lw_regwrite", RegWrite, 1); chk("lw_resultsrc", ResultSrc, 1);
    step(4);
    chk("lw_back", state, 0);
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1; step(0); step(1);
    chk("sub_s6", state, 6); chk("sub_alu", ALUControl, 1); chk("sub_srca", ALUSrcA, 2);
    step(6);
    chk("sub_s8", state, 8); chk("sub_regwrite", RegWrite, 1);
    step(8);
    funct7b5 = 1'b0; step(0); step(1);
    chk("add_alu", ALUControl, 0);
    step(6); step(8);
    op = 7'b0010011; funct7b5 = 1'b1; step(0); step(1);
    chk("addi_s7", state, 7); chk("addi_alu", ALUControl, 0);
    chk("addi_srcb", ALUSrcB, 1); chk("addi_imm", ImmSrc, 0);
    step(7); step(8);
    op = 7'b1100011; step(0); step(1);
    zero = 1'b1; #1 chk("beq_taken", PCWrite, 1);
    zero = 1'b0; #1 chk("beq_not", PCWrite, 0);
    chk("beq_alu", ALUControl, 1); chk("beq_imm", ImmSrc, 2);
    step(9);
    chk("beq_back", state, 0);
    op = 7'b0000000; step(0);
    chk("nop_s1", state, 1); chk("nop_rw", RegWrite, 0); chk("nop_pcw", PCWrite, 0);
    step(1);
    chk("nop_back", state, 0);
    op = 7'b0000011; step(0); step(1); step(2);
    #2 rst = 1'b1; exp_state = 0;
    #1 chk("rst_mid_state", state, 0); chk("rst_mid_ir", IRWrite, 1); chk("rst_mid_pcw", PCWrite, 1);
    step(0);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 7) == 7) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      run(o, 3'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
